// File: rtl/uart_rx_oversample.sv
// uart_rx_oversample: 8N1 oversampling UART receiver, LSB first.
// A two-flop chain synchronizes rxd.  A local divider makes the OVERSAMPLE x
// baud tick, and the tick phase restarts on every start edge.  The FSM picks
// the mid-bit sample points and checks the stop bit.
// Optional build macro UART_RX_MAJORITY_EN: each sample point takes three
// samples, on the ticks at the nominal index -1, 0 and +1.  The bit value is
// the 2-of-3 majority, and the decision is made on the +1 tick.
module uart_rx_oversample #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int S_W   = $clog2(OVERSAMPLE);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [S_W-1:0]   S_LAST   = S_W'(OVERSAMPLE - 1);

`ifdef UART_RX_MAJORITY_EN
  // The decision moves one tick past each nominal point.  Entering DATA with
  // s_cnt=1 keeps the later sample points on the original bit grid.
  localparam logic [S_W-1:0] START_IDX  = S_W'(OVERSAMPLE / 2);
  localparam logic [S_W-1:0] BIT_IDX    = S_W'(0);
  localparam logic [S_W-1:0] DATA_ENTRY = S_W'(1);
`else
  localparam logic [S_W-1:0] START_IDX  = S_W'(OVERSAMPLE / 2 - 1);
  localparam logic [S_W-1:0] BIT_IDX    = S_W'(OVERSAMPLE - 1);
  localparam logic [S_W-1:0] DATA_ENTRY = S_W'(0);
`endif

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] STOP      = 3'd3;
  localparam logic [2:0] WAIT_HIGH = 3'd4;

  logic             sync1_q;
  logic             rx_s_q;
  logic [2:0]       state_q, state_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [S_W-1:0]   s_cnt_q, s_cnt_d;
  logic [2:0]       b_cnt_q, b_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_out_q, data_out_d;
  logic             data_valid_q, data_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             busy_q, busy_d;
  logic             tick_s;
  logic             sample_s;

`ifdef UART_RX_MAJORITY_EN
  logic [1:0]       hist_q, hist_d;

  // 2-of-3 majority vote
  function automatic logic maj3(input logic a, input logic b, input logic c);
    maj3 = (a & b) | (a & c) | (b & c);
  endfunction

  // The history holds the samples from the two previous ticks: [1] = -1, [0] = nominal
  always_comb begin
    hist_d   = hist_q;
    sample_s = maj3(hist_q[1], hist_q[0], rx_s_q);
    if (tick_s) begin
      hist_d = {hist_q[0], rx_s_q};
    end else begin
      hist_d = hist_q;
    end
  end

  // Sample history register
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= 2'b11;
    end else begin
      hist_q <= hist_d;
    end
  end
`else
  // Single sample at the nominal index
  always_comb begin
    sample_s = rx_s_q;
  end
`endif

  // Two-flop synchronizer for the asynchronous serial line; idles high
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= rxd;
      rx_s_q  <= sync1_q;
    end
  end

  // Baud tick: the divider is held at zero in IDLE so the tick phase follows the start edge
  always_comb begin
    tick_s = (state_q != IDLE) && (div_cnt_q == DIV_LAST);
    if (state_q == IDLE) begin
      div_cnt_d = {DIV_W{1'b0}};
    end else if (tick_s) begin
      div_cnt_d = {DIV_W{1'b0}};
    end else begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
    end
  end

  // Receive FSM: finds the mid-bit sample points, shifts in the data and checks the stop bit
  always_comb begin
    state_d      = state_q;
    b_cnt_d      = b_cnt_q;
    shift_d      = shift_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    if (tick_s) begin
      s_cnt_d = (s_cnt_q == S_LAST) ? {S_W{1'b0}} : (s_cnt_q + S_W'(1));
    end else begin
      s_cnt_d = s_cnt_q;
    end

    case (state_q)
      IDLE: begin
        s_cnt_d = {S_W{1'b0}};
        b_cnt_d = 3'd0;
        if (!rx_s_q) begin
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (tick_s && (s_cnt_q == START_IDX)) begin
          if (!sample_s) begin
            state_d = DATA;
            s_cnt_d = DATA_ENTRY;
            b_cnt_d = 3'd0;
          end else begin
            // Start bit did not hold until mid-bit: treat it as a glitch
            state_d = IDLE;
          end
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        if (tick_s && (s_cnt_q == BIT_IDX)) begin
          shift_d = {sample_s, shift_q[7:1]};
          if (b_cnt_q == 3'd7) begin
            state_d = STOP;
            b_cnt_d = 3'd0;
          end else begin
            b_cnt_d = b_cnt_q + 3'd1;
          end
        end else begin
          state_d = DATA;
        end
      end
      STOP: begin
        if (tick_s && (s_cnt_q == BIT_IDX)) begin
          if (sample_s) begin
            data_out_d   = shift_q;
            data_valid_d = 1'b1;
            state_d      = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = WAIT_HIGH;
          end
        end else begin
          state_d = STOP;
        end
      end
      WAIT_HIGH: begin
        // A break (line held low) must not retrigger reception
        if (rx_s_q) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT_HIGH;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      div_cnt_q    <= {DIV_W{1'b0}};
      s_cnt_q      <= {S_W{1'b0}};
      b_cnt_q      <= 3'd0;
      shift_q      <= 8'h00;
      data_out_q   <= 8'h00;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_cnt_q    <= div_cnt_d;
      s_cnt_q      <= s_cnt_d;
      b_cnt_q      <= b_cnt_d;
      shift_q      <= shift_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Self-checking bench for uart_rx_oversample.  It uses a scaled clock so the
// divider is 10 and one bit lasts 160 clk.  Expected frames go into a queue as
// they are sent.  A monitor pops and checks one entry per valid/error pulse.
module tb_uart_rx_oversample;

  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 10_000;
  localparam int OS       = 16;
  localparam int DIV      = CLK_FREQ / (BAUD * OS);
  localparam int BITC     = DIV * OS;
  localparam int PERIOD   = 10;
`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ_EXTRA = DIV;
`else
  localparam int MAJ_EXTRA = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  typedef struct packed {
    logic       is_err;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  longint     vtime_q[$];
  longint     t0 = 0;
  int         checks = 0;
  int         failures = 0;
  int         n_pulses = 0;
  int         n_pushed = 0;
  logic [7:0] last_good = 8'h00;

  uart_rx_oversample #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .data_out  (data_out),
    .data_valid(data_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #(PERIOD / 2) clk = ~clk;

  // Scoreboard monitor: each valid or error pulse pops and checks one expected entry
  always @(negedge clk) begin
    if (!rst && (data_valid || frame_err)) begin
      exp_t e;
      n_pulses++;
      if (data_valid) vtime_q.push_back($time);
      checks++;
      if (data_valid && frame_err) begin
        failures++;
        $display("FAIL pulse_exclusive: data_valid=%0b frame_err=%0b, required not both", data_valid, frame_err);
      end
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse: data_valid=%0b frame_err=%0b data_out=%02h, required no pulse", data_valid, frame_err, data_out);
      end else begin
        e = exp_q.pop_front();
        if (frame_err !== e.is_err) begin
          failures++;
          $display("FAIL pulse_kind: frame_err=%0b, required %0b", frame_err, e.is_err);
        end
        checks++;
        if (data_out !== e.data) begin
          failures++;
          $display("FAIL pulse_data: data_out=%02h, required %02h", data_out, e.data);
        end
        checks++;
        if (busy !== e.is_err) begin
          failures++;
          $display("FAIL pulse_busy: busy=%0b, required %0b", busy, e.is_err);
        end
      end
    end
  end

  task automatic push_good(input logic [7:0] d);
    exp_q.push_back({1'b0, d});
    last_good = d;
    n_pushed++;
  endtask

  task automatic push_err();
    exp_q.push_back({1'b1, last_good});
    n_pushed++;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
  endtask

  // Sends one 8N1 frame, one rxd update per clock.  stop_low holds the line
  // low after the data bits.  A glitch inverts the line for glen clocks from
  // cycle gat.  When abort_at >= 0, reset is pulsed at that cycle and the
  // frame is dropped.
  task automatic send_frame(input logic [7:0] d, input int stop_low,
                            input int gat, input int glen, input int abort_at);
    int   total;
    logic lvl;
    total = 9 * BITC + stop_low + BITC;
    for (int c = 0; c < total; c++) begin
      @(posedge clk);
      #1;
      if (c == abort_at) begin
        rst = 1'b1;
        rxd = 1'b1;
        wait_cycles(2);
        #1;
        rst = 1'b0;
        return;
      end
      if (c < BITC) lvl = 1'b0;
      else if (c < 9 * BITC) lvl = d[(c / BITC) - 1];
      else if (c < 9 * BITC + stop_low) lvl = 1'b0;
      else lvl = 1'b1;
      if (c >= gat && c < gat + glen) lvl = ~lvl;
      if (c == 0) t0 = $time;
      rxd = lvl;
    end
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 20 * BITC && exp_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_timeout: %0d pulses outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rxd = 1'b1;
    wait_cycles(5);
    #1;
    rst = 1'b0;
    wait_cycles(10 * BITC);
    @(negedge clk);
    checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %0b, required 0", data_valid); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_err: got %0b, required 0", frame_err); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b, required 0", busy); end
    checks++; if (data_out !== 8'h00) begin failures++; $display("FAIL reset_data: got %02h, required 00", data_out); end
  endtask

  task automatic test_basic();
    longint lat;
    longint exp_lat;
    vtime_q.delete();
    push_good(8'h55);
    send_frame(8'h55, 0, -1, 0, -1);
    wait_drain("basic");
    checks++;
    if (vtime_q.size() != 1) begin
      failures++;
      $display("FAIL basic_pulses: got %0d valid pulses, required 1", vtime_q.size());
    end else begin
      lat = (vtime_q[0] - t0) / PERIOD;
      exp_lat = 2 + DIV * (OS / 2 + 9 * OS) + MAJ_EXTRA;
      if (lat < exp_lat - 1 || lat > exp_lat + 1) begin
        failures++;
        $display("FAIL basic_latency: got %0d clk, required %0d +-1", lat, exp_lat);
      end
    end
  endtask

  task automatic test_glitch();
    @(posedge clk);
    #1;
    rxd = 1'b0;
    wait_cycles(20);
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL glitch_busy_high: got %0b, required 1", busy); end
    wait_cycles(BITC * 30 / 160 - 20);
    #1;
    rxd = 1'b1;
    wait_cycles(2 * BITC);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL glitch_busy_low: got %0b, required 0", busy); end
    checks++; if (data_out !== 8'h55) begin failures++; $display("FAIL glitch_data: got %02h, required 55", data_out); end
  endtask

  task automatic test_frame_err();
    push_err();
    send_frame(8'hA3, 3 * BITC, -1, 0, -1);
    wait_drain("ferr");
    @(negedge clk);
    checks++; if (data_out !== 8'h55) begin failures++; $display("FAIL ferr_data_kept: got %02h, required 55", data_out); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ferr_busy_after: got %0b, required 0", busy); end
    push_good(8'h3C);
    send_frame(8'h3C, 0, -1, 0, -1);
    wait_drain("after_ferr");
    checks++; if (data_out !== 8'h3C) begin failures++; $display("FAIL after_ferr_data: got %02h, required 3c", data_out); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] pat [3];
    longint gap;
    pat[0] = 8'h00; pat[1] = 8'hFF; pat[2] = 8'h81;
    vtime_q.delete();
    for (int k = 0; k < 3; k++) begin
      push_good(pat[k]);
      send_frame(pat[k], 0, -1, 0, -1);
    end
    wait_drain("b2b");
    checks++;
    if (vtime_q.size() != 3) begin
      failures++;
      $display("FAIL b2b_pulses: got %0d valid pulses, required 3", vtime_q.size());
    end else begin
      for (int k = 1; k < 3; k++) begin
        gap = (vtime_q[k] - vtime_q[k-1]) / PERIOD;
        checks++;
        if (gap < 10 * BITC - 2 || gap > 10 * BITC + 2) begin
          failures++;
          $display("FAIL b2b_spacing: got %0d clk, required %0d +-2", gap, 10 * BITC);
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    send_frame(8'hC6, 0, -1, 0, 4 * BITC + BITC / 2);
    last_good = 8'h00;
    @(negedge clk);
    checks++; if (data_out !== 8'h00) begin failures++; $display("FAIL midrst_data: got %02h, required 00", data_out); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %0b, required 0", busy); end
    wait_cycles(12 * BITC);
    push_good(8'h12);
    send_frame(8'h12, 0, -1, 0, -1);
    wait_drain("midrst");
    checks++; if (data_out !== 8'h12) begin failures++; $display("FAIL midrst_next: got %02h, required 12", data_out); end
  endtask

  task automatic test_majority();
    logic [7:0] want;
`ifdef UART_RX_MAJORITY_EN
    want = 8'h5A;
`else
    want = 8'h5E;
`endif
    push_good(want);
    send_frame(8'h5A, 0, 3 * BITC + BITC / 2 - 4, BITC * 300 / 5200, -1);
    wait_drain("maj");
    checks++; if (data_out !== want) begin failures++; $display("FAIL glitch_bit2: got %02h, required %02h", data_out, want); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_reset_mid_frame();
    test_majority();
    wait_cycles(2 * BITC);
    checks++;
    if (n_pulses != n_pushed) begin
      failures++;
      $display("FAIL pulse_count: got %0d pulses, required %0d", n_pulses, n_pushed);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
